// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU wrapper.
//   state_t      : wrapper FSM state (IDLE / SETTLE / HOLD)
//   alu_op_t     : opaque 2-bit ALU operation code
//   ALU_WIDTH    : datapath width of the ALU instance
//   SETTLE_CNT_W : width of the settle-cycle down counter (SETTLE_CYCLES <= 255)
package alu_seq_pkg;

  localparam int ALU_WIDTH    = 64;
  localparam int SETTLE_CNT_W = 8;

  typedef logic [1:0] alu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage : alu_seq_pkg

// File: rtl/alu64bit_seq.sv
// Sequential front-end/back-end wrapper around a combinational ripple ALU.
// A request is registered onto the ALU inputs, held for SETTLE_CYCLES clock
// edges so the ripple chain resolves, then s/cout plus zero/negative flags
// are captured into an output register offered downstream.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. A requester holds in_valid and its payload until accepted. The
// result holds out_valid and its payload until out_ready is seen. in_ready is
// high only in IDLE; out_valid is high only in HOLD.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_cin, in_op  request payload
//   in_chain                   take cin from the stored carry (chain build only)
//   alu_a/alu_b/alu_cin/alu_op registered drive to the ALU
//   alu_s, alu_cout            combinational results from the ALU
//   out_valid/out_ready        result handshake
//   out_s, out_cout            captured result
//   out_zero, out_neg          flags derived from the captured result
//   o_dbg_state                current FSM state for observation
//
// Build option: define ALU_SEQ_CARRY_CHAIN_EN to keep the carry out of every
// captured result and let a request with in_chain = 1 use it as its carry in,
// so multiword adds can be issued as successive requests.
module alu64bit_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 4          // legal range 1..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  alu_op_t          in_op,
  input  logic             in_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output alu_op_t          alu_op,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output state_t           o_dbg_state
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [SETTLE_CNT_W-1:0] r_cnt;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_release;
  logic                    w_cin;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_capture = (r_state == SETTLE) && (r_cnt == '0);
  assign w_release = (r_state == HOLD) && out_ready;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic r_carry;

  assign w_cin = in_chain ? r_carry : in_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_capture) begin
      r_carry <= alu_cout;
    end
  end
`else
  logic w_unused_chain;

  assign w_unused_chain = in_chain;
  assign w_cin          = in_cin;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = SETTLE;
      SETTLE:  if (w_capture) w_next = HOLD;
      HOLD:    if (w_release) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    in_ready    = (r_state == IDLE);
    out_valid   = (r_state == HOLD);
    o_dbg_state = r_state;
  end

  // Settle counter: loaded at acceptance, counts down to the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= SETTLE_LOAD;
    end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // ALU drive registers: change only on acceptance, so they stay at the last
  // accepted operands through capture and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      alu_op  <= '0;
    end else if (w_accept) begin
      alu_a   <= in_a;
      alu_b   <= in_b;
      alu_cin <= w_cin;
      alu_op  <= in_op;
    end
  end

  // Result register: flags come from the value being captured, so they can
  // never disagree with out_s even if alu_s later moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_s    <= '0;
      out_cout <= 1'b0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (w_capture) begin
      out_s    <= alu_s;
      out_cout <= alu_cout;
      out_zero <= (alu_s == '0);
      out_neg  <= alu_s[WIDTH-1];
    end
  end

endmodule : alu64bit_seq
